// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// clock-to-baud divider used by both the transmit and receive paths.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Clock cycles per bit; integer division, so the line rate is approximate.
  function automatic int unsigned uart_scale(input int unsigned clk_mhz,
                                             input int unsigned boadrate);
    return (clk_mhz * 1000 * 1000) / boadrate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 so an idle-high
// line does not look like an edge when reset is released.
module uart_rx_sync (
  input  logic clk,
  input  logic arstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_reader.sv
// 8N1 UART receiver: start bit validated at mid-bit, data sampled at bit centres,
// bytes delivered through a one-entry holding register with framing/overrun pulses.
module uart_rx_reader
  import uart_pkg::*;
#(
  parameter int unsigned clk_mhz  = 50,
  parameter int unsigned boadrate = 9600
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   rx,
  output logic                   valid,
  input  logic                   ready,
  output logic [UART_DATA_W-1:0] data,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [1:0]             fsm_state
);

  localparam int unsigned SCALE = uart_scale(clk_mhz, boadrate);
  localparam int unsigned HALF  = SCALE / 2;
  localparam logic [31:0] RELOAD_BIT  = 32'(SCALE - 1);
  localparam logic [31:0] RELOAD_HALF = 32'(HALF - 1);
  localparam logic [UART_IDX_W-1:0] IDX_LAST = UART_IDX_W'(UART_DATA_W - 1);

  logic rx_s;
  logic rx_prev;

  rx_state_t               state, state_next;
  logic [31:0]             cnt, cnt_next;
  logic [UART_DATA_W-1:0]  shift, shift_next;
  logic [UART_IDX_W-1:0]   bit_idx, idx_next;
  logic                    valid_next;
  logic [UART_DATA_W-1:0]  data_next;
  logic                    frame_err_next;
  logic                    overrun_next;
  logic                    tick;

  uart_rx_sync u_sync (
    .clk   (clk),
    .arstn (arstn),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!arstn) rx_prev <= 1'b1;
    else        rx_prev <= rx_s;
  end

  assign tick      = (cnt == 32'd0);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      shift     <= '0;
      bit_idx   <= '0;
      valid     <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      shift     <= shift_next;
      bit_idx   <= idx_next;
      valid     <= valid_next;
      data      <= data_next;
      frame_err <= frame_err_next;
      overrun   <= overrun_next;
    end
  end

  // Downstream handshake: a byte transfers in any cycle with valid & ready;
  // valid never drops without a transfer and data holds while valid is high,
  // except when a transfer and a new commit land in the same cycle.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    shift_next     = shift;
    idx_next       = bit_idx;
    valid_next     = valid;
    data_next      = data;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;

    if (valid && ready) valid_next = 1'b0;

    case (state)
      IDLE: begin
        // A falling edge is required, so a held-low (break) line never retriggers.
        if (rx_prev && !rx_s) begin
          state_next = START;
          cnt_next   = RELOAD_HALF;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_next = DATA;
            cnt_next   = RELOAD_BIT;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - 32'd1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = {rx_s, shift[UART_DATA_W-1:1]};
          idx_next   = bit_idx + UART_IDX_W'(1);
          cnt_next   = RELOAD_BIT;
          if (bit_idx == IDX_LAST) state_next = STOP;
        end else begin
          cnt_next = cnt - 32'd1;
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a start edge right after it be caught.
        if (tick) begin
          state_next = IDLE;
          if (rx_s) begin
            if (!valid || ready) begin
              valid_next = 1'b1;
              data_next  = shift;
            end else begin
              overrun_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt - 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_reader.sv
// Directed bench for uart_rx_reader at scale=10, half=5: a frame-level model of the
// holding register is checked every cycle, plus literal expectations per scenario.
module tb_uart_rx_reader;

  localparam int SCALE = 10;
  // Pin start edge to first visible result: 2 sync + half + 9 bits + 1 register.
  localparam int OUT_LAT = 2 + SCALE / 2 + 9 * SCALE + 1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       valid;
  logic [7:0] data;
  logic       frame_err;
  logic       overrun;
  logic [1:0] fsm_state;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  typedef struct {int cyc; bit good; logic [7:0] data;} ev_t;
  typedef struct {int cyc; logic [7:0] data;} beat_t;

  ev_t        ev_q[$];
  logic [7:0] exp_q[$];
  beat_t      beat_q[$];
  int         ferr_q[$];
  int         ovr_q[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  uart_rx_reader #(.clk_mhz(1), .boadrate(100000)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .rx        (rx),
    .valid     (valid),
    .ready     (ready),
    .data      (data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    step(SCALE);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_q.push_back('{cyc + OUT_LAT, stop, b});
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k]);
    drive_bit(stop);
  endtask

  task automatic clear_logs();
    beat_q.delete();
    ferr_q.delete();
    ovr_q.delete();
  endtask

  task automatic wait_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------- scoreboard / model ----------------
  always @(negedge clk) begin : compare
    logic       nv;
    logic [7:0] nd;
    logic       nf;
    logic       no;
    ev_t        ev;
    if (chk_en) begin
      check("valid", 32'(valid), 32'(m_valid));
      check("data", 32'(data), 32'(m_data));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (valid && ready) begin
        beat_q.push_back('{cyc, data});
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL accept_unexpected: got %0h, expected no beat (cycle %0d)", data, cyc);
        end else begin
          check("accept_data", 32'(data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err) ferr_q.push_back(cyc);
      if (overrun)   ovr_q.push_back(cyc);

      if (!arstn) begin
        nv = 1'b0; nd = 8'h00; nf = 1'b0; no = 1'b0;
        ev_q.delete();
      end else begin
        nv = m_valid; nd = m_data; nf = 1'b0; no = 1'b0;
        if (m_valid && ready) nv = 1'b0;
        if (ev_q.size() > 0 && ev_q[0].cyc == cyc + 1) begin
          ev = ev_q.pop_front();
          if (!ev.good)                nf = 1'b1;
          else if (!m_valid || ready)  begin nv = 1'b1; nd = ev.data; end
          else                         no = 1'b1;
        end
      end
      m_valid = nv;
      m_data  = nd;
      m_ferr  = nf;
      m_ovr   = no;
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    int p;
    int p2;
    logic [7:0] b2b [3];
    logic [7:0] rb;
    b2b = '{8'h00, 8'hFF, 8'h3C};
    rb  = 8'hC3;

    step(3);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    chk_en = 1'b1;
    arstn  = 1'b1;
    idle(10);

    // Single byte
    ready = 1'b1;
    clear_logs();
    p = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(10);
    check("single_beats", 32'(beat_q.size()), 32'd1);
    if (beat_q.size() > 0) begin
      check("single_cycle", 32'(beat_q[0].cyc), 32'(p + 98));
      check("single_data", 32'(beat_q[0].data), 32'hA5);
    end
    check("single_flags", 32'(ferr_q.size() + ovr_q.size()), 32'd0);

    // Back-to-back, no idle gap
    clear_logs();
    p = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(b2b[i]);
      send_frame(b2b[i], 1'b1);
    end
    idle(10);
    check("b2b_beats", 32'(beat_q.size()), 32'd3);
    if (beat_q.size() == 3) begin
      check("b2b_data0", 32'(beat_q[0].data), 32'h00);
      check("b2b_data1", 32'(beat_q[1].data), 32'hFF);
      check("b2b_data2", 32'(beat_q[2].data), 32'h3C);
      check("b2b_cycle2", 32'(beat_q[2].cyc), 32'(p + 298));
    end
    check("b2b_flags", 32'(ferr_q.size() + ovr_q.size()), 32'd0);

    // Glitch: 3 low cycles; start sample at E+5 sees 1
    clear_logs();
    p = cyc;
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    wait_cycle(p + 7);
    check("glitch_start", 32'(fsm_state), 32'(ST_START));
    @(negedge clk);
    check("glitch_idle", 32'(fsm_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    idle(20);
    check("glitch_nothing", 32'(beat_q.size() + ferr_q.size() + ovr_q.size()), 32'd0);

    // Framing error, then a 50-cycle break
    clear_logs();
    p = cyc;
    send_frame(8'h55, 1'b0);
    check("ferr_count", 32'(ferr_q.size()), 32'd1);
    if (ferr_q.size() > 0) check("ferr_cycle", 32'(ferr_q[0]), 32'(p + 98));
    repeat (50) begin
      @(negedge clk);
      check("break_idle", 32'(fsm_state), 32'(ST_IDLE));
    end
    @(posedge clk);
    #1;
    idle(20);
    check("ferr_no_beat", 32'(beat_q.size() + ovr_q.size()), 32'd0);
    check("ferr_valid", 32'(valid), 32'h0);

    // Overrun with ready held low
    ready = 1'b0;
    clear_logs();
    send_frame(8'h11, 1'b1);
    p2 = cyc;
    send_frame(8'h22, 1'b1);
    idle(5);
    check("ovr_count", 32'(ovr_q.size()), 32'd1);
    if (ovr_q.size() > 0) check("ovr_cycle", 32'(ovr_q[0]), 32'(p2 + 98));
    check("ovr_held_valid", 32'(valid), 32'h1);
    check("ovr_held_data", 32'(data), 32'h11);
    exp_q.push_back(8'h11);
    ready = 1'b1;
    step(4);
    check("ovr_drain_beats", 32'(beat_q.size()), 32'd1);
    if (beat_q.size() > 0) check("ovr_drain_data", 32'(beat_q[0].data), 32'h11);
    check("ovr_drain_valid", 32'(valid), 32'h0);

    // Reset during bit 4 of 8'hC3 while an unread byte sits in the holding register
    ready = 1'b0;
    clear_logs();
    send_frame(8'h99, 1'b1);
    idle(5);
    check("pre_rst_data", 32'(data), 32'h99);
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(rb[k]);
    rx = rb[4];
    step(5);
    arstn = 1'b0;
    rx    = 1'b1;
    step(3);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_flags", 32'({frame_err, overrun}), 32'h0);
    check("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    arstn = 1'b1;
    idle(20);
    ready = 1'b1;
    clear_logs();
    p = cyc;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(10);
    check("post_rst_beats", 32'(beat_q.size()), 32'd1);
    if (beat_q.size() > 0) begin
      check("post_rst_data", 32'(beat_q[0].data), 32'h7E);
      check("post_rst_cycle", 32'(beat_q[0].cyc), 32'(p + 98));
    end

    idle(5);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("events_drained", 32'(ev_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_reader.md
# uart_rx_reader

Asynchronous serial receiver for 8N1 frames, LSB first, idle-high line. It is the receive counterpart of the existing UART transmit path and runs at the same `clk_mhz`/`boadrate` parameterisation. It synchronises the `rx` pin, validates the start bit at mid-bit and samples each data bit at its centre. Received bytes are delivered on a valid/ready downstream port with a one-entry holding register and error flags.

## Interface
- `clk_mhz`, default 50: system clock frequency in MHz.
- `boadrate`, default 9600: line rate in baud.
- `clk`  in  1  system clock.
- `arstn`  in  1  reset; synchronous, active-low (sampled on posedge `clk`).
- `rx`  in  1  asynchronous serial line, idle 1.
- `valid`  out  1  byte available in the holding register.
- `ready`  in  1  downstream accepts the byte when `valid & ready`.
- `data`  out  8  received byte; stable while `valid`=1.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `overrun`  out  1  one-cycle pulse when a good byte completes while the holding register is still full.

## Operation
- Constants: `scale = clk_mhz*1000*1000/boadrate` (integer division), `half = scale/2`. Legal range is `scale >= 4`.
- Bit counter: 32 bits; it counts down to 0 and is reloaded on each sample point.
- Input path: 2-flop synchroniser produces `rx_s`, reset to 1. A third register `rx_prev` holds the previous `rx_s`, reset to 1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On `rx_prev`=1 and `rx_s`=0, go to START and load the counter with `half-1`.
  - A line held low (break) never retriggers, because a 1→0 edge is required.
- START, counter reaches 0:
  - `rx_s`=0: go to DATA, load `scale-1`, bit index = 0.
  - `rx_s`=1: glitch; go to IDLE and emit no flags.
- DATA, counter reaches 0:
  - Shift the register right, inserting `rx_s` at bit 7; increment the bit index and reload `scale-1`.
  - After the 8th sample (index 7), go to STOP.
- STOP, counter reaches 0, then always go to IDLE:
  - `rx_s`=1 and `valid`=0: load `data`, set `valid`.
  - `rx_s`=1, `valid`=1, `ready`=1 in the same cycle: load the new byte; `valid` stays 1; no overrun.
  - `rx_s`=1, `valid`=1, `ready`=0: drop the new byte, keep the old one, pulse `overrun`.
  - `rx_s`=0: pulse `frame_err`; the byte is discarded and `valid` is unchanged.
- Output handshake:
  - `valid` clears on `valid & ready` unless a new byte is committed in that same cycle.
  - `data` must not change while `valid`=1 except on a same-cycle accept plus commit.
- Reset mid-frame returns the block to IDLE immediately; the partial byte is lost.

## Timing
- Reset values:
  - `valid`=0, `data`=8'h00, `frame_err`=0, `overrun`=0.
  - FSM=IDLE, counter=0, shift register=0, synchroniser and `rx_prev`=1.
- Pin to `rx_s`: 2 cycles. Edge detection happens in the cycle `rx_s` first reads 0 (cycle E).
- Start sample: cycle E+`half`.
- Data bit k (k=0..7): cycle E+`half`+(k+1)·`scale`.
- Stop sample: cycle E+`half`+9·`scale`.
- `valid`, `frame_err` and `overrun` are registered and first visible in the cycle after the stop sample.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends, so a start edge immediately following the stop bit is caught.
- Error pulses are exactly 1 cycle wide.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP).
  - Function `uart_scale(clk_mhz, boadrate)`, also used by the transmit side.
  - Constant `UART_DATA_W = 8`.
- Sub-module `uart_rx_sync`: 2-flop synchroniser, reset value 1, reusable for other asynchronous inputs.
- Everything else stays in one module: counter, FSM, shifter and holding register.

## Test plan
All scenarios use `clk_mhz=1`, `boadrate=100000`, giving `scale=10` and `half=5`.
- Single byte: send 8'hA5 with `ready`=1. Required: `valid` for 1 cycle with `data`=8'hA5, at cycle E+96; no flags.
- Back-to-back: send 8'h00, 8'hFF, 8'h3C with no idle gap and `ready`=1. Required: three valid beats with the correct data; no flags.
- Glitch: `rx` low for 3 cycles, then high. Required: FSM returns to IDLE at E+5; no `valid`, no flags.
- Framing: send 8'h55 with the stop bit driven 0. Required: `frame_err` pulse at E+96; `valid` stays 0. Then hold `rx` low for 50 cycles and release. Required: no new frame starts until a fresh 1→0 edge.
- Overrun: hold `ready`=0 and send 8'h11 then 8'h22. Required: `data`=8'h11 held; `overrun` pulse at the end of the second frame. Then raise `ready`: one beat of 8'h11, after which `valid`=0.
- Reset mid-frame: assert `arstn`=0 during bit 4 of 8'hC3, then release with the line idle. Required: all outputs at reset values; the next full frame 8'h7E is received correctly.
